// File: rtl/shift8_seq.sv
// shift8_seq: command sequencer for an external Shift8 register.
// Accepts one command per valid/ready handshake, drives ld/en/dir/sd/d for
// the register, and returns the final register contents with a done pulse.
// Optional feature macro: SHIFT8_SEQ_ROTATE_EN (ROTATE feeds q back into sd).
`timescale 1ns/1ps

module shift8_seq #(
  parameter int MAX_SHIFT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_dir,
  input  logic [3:0] cmd_cnt,
  input  logic       cmd_fill,
  input  logic [7:0] cmd_data,
  output logic       sr_ld,
  output logic       sr_en,
  output logic       sr_dir,
  output logic       sr_sd,
  output logic [7:0] sr_d,
  input  logic [7:0] sr_q,
  output logic       done,
  output logic [7:0] result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD_SHIFT = 2'b00;
  localparam logic [1:0] OP_SHIFT      = 2'b01;
  localparam logic [1:0] OP_ROTATE     = 2'b10;
  localparam logic [1:0] OP_CLEAR      = 2'b11;

  localparam logic [3:0] MAX_CNT = 4'(MAX_SHIFT);

  logic [1:0] state;
  logic [1:0] op_q;
  logic [3:0] cnt_q;
  logic       fill_q;
  logic [1:0] op_dec;
  logic [3:0] cnt_sat;

  // Decode the incoming opcode and saturate the requested shift count.
  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    op_dec  = cmd_op;
`ifndef SHIFT8_SEQ_ROTATE_EN
    if (cmd_op == OP_ROTATE) op_dec = OP_LOAD_SHIFT;
`endif
    cnt_sat = (cmd_cnt > MAX_CNT) ? MAX_CNT : cmd_cnt;
  end

  assign cmd_ready = (state == S_IDLE);

`ifdef SHIFT8_SEQ_ROTATE_EN
  // Rotation takes the bit leaving the register as the serial input.
  assign sr_sd = (state == S_SHIFT && op_q == OP_ROTATE)
               ? (sr_dir ? sr_q[0] : sr_q[7])
               : fill_q;
`else
  assign sr_sd = fill_q;
`endif

  // FSM, shift counter and registered register-control outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op_q   <= OP_LOAD_SHIFT;
      cnt_q  <= 4'd0;
      fill_q <= 1'b0;
      sr_ld  <= 1'b0;
      sr_en  <= 1'b0;
      sr_dir <= 1'b0;
      sr_d   <= 8'h00;
      done   <= 1'b0;
      result <= 8'h00;
    end else begin
      sr_ld <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_dec;
            cnt_q  <= cnt_sat;
            fill_q <= cmd_fill;
            sr_dir <= cmd_dir;
            if (op_dec == OP_SHIFT) begin
              if (cnt_sat == 4'd0) begin
                state <= S_DONE;
              end else begin
                state <= S_SHIFT;
                sr_en <= 1'b1;
              end
            end else begin
              state <= S_LOAD;
              sr_ld <= 1'b1;
              sr_d  <= (op_dec == OP_CLEAR) ? 8'h00 : cmd_data;
            end
          end
        end
        S_LOAD: begin
          if (cnt_q != 4'd0 && op_q != OP_CLEAR) begin
            state <= S_SHIFT;
            sr_en <= 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
        S_SHIFT: begin
          if (cnt_q == 4'd1) begin
            state <= S_DONE;
            sr_en <= 1'b0;
            cnt_q <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          done   <= 1'b1;
          result <= sr_q;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift8_seq.sv
// tb_shift8_seq: self-checking bench for shift8_seq with a behavioural
// Shift8 register in the loop and an arithmetic reference model.
`timescale 1ns/1ps

module tb_shift8_seq;

  localparam int MAX_SHIFT = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_cnt = 4'd0;
  logic       cmd_fill = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       sr_ld, sr_en, sr_dir, sr_sd;
  logic [7:0] sr_d;
  logic [7:0] sr_q = 8'h00;
  logic       done;
  logic [7:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  logic [7:0] ref_q = 8'h00;

  shift8_seq #(.MAX_SHIFT(MAX_SHIFT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_cnt(cmd_cnt),
    .cmd_fill(cmd_fill), .cmd_data(cmd_data),
    .sr_ld(sr_ld), .sr_en(sr_en), .sr_dir(sr_dir), .sr_sd(sr_sd),
    .sr_d(sr_d), .sr_q(sr_q), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Shift8 register: ld beats en; not reset so its contents survive a sequencer reset.
  always @(posedge clk) begin
    if (sr_ld)      sr_q <= sr_d;
    else if (sr_en) sr_q <= sr_dir ? {sr_sd, sr_q[7:1]} : {sr_q[6:0], sr_sd};
  end

  always @(negedge clk) if (sr_ld && sr_en) overlap++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: result and timing from the command's meaning, not the FSM.
  function automatic int eff_op(input logic [1:0] op);
`ifdef SHIFT8_SEQ_ROTATE_EN
    return int'(op);
`else
    return (op == 2'b10) ? 0 : int'(op);
`endif
  endfunction

  function automatic int sat(input logic [3:0] cnt);
    return (int'(cnt) > MAX_SHIFT) ? MAX_SHIFT : int'(cnt);
  endfunction

  function automatic logic [7:0] model(input logic [1:0] op, input logic dir, input logic [3:0] cnt,
                                       input logic fill, input logic [7:0] data, input logic [7:0] cur);
    int n, v, ones, r;
    n = sat(cnt);
    case (eff_op(op))
      3:       return 8'h00;
      1:       v = int'(cur);
      default: v = int'(data);
    endcase
    ones = (1 << n) - 1;
    if (eff_op(op) == 2)
      r = dir ? ((v >> n) | (v << (8 - n))) : ((v << n) | (v >> (8 - n)));
    else if (dir)
      r = (v >> n) | (fill ? (ones << (8 - n)) : 0);
    else
      r = (v << n) | (fill ? ones : 0);
    return 8'(r & 255);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [3:0] cnt);
    case (eff_op(op))
      3:       return 2;
      1:       return 1 + sat(cnt);
      default: return 2 + sat(cnt);
    endcase
  endfunction

  // Issue one command and measure it; called #1 after an edge, returns in the done cycle.
  task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [3:0] cnt,
                         input logic fill, input logic [7:0] data,
                         output logic [7:0] res, output int lat, output int nld,
                         output int nen, output logic busy_ok);
    int w = 0;
    while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_cnt = cnt;
    cmd_fill = fill; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; nld = 0; nen = 0; busy_ok = 1'b1;
    while (lat < 40) begin
      if (sr_ld) nld++;
      if (sr_en) nen++;
      if (cmd_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
    res = result;
  endtask

  typedef struct {
    logic [1:0] op;
    logic       dir;
    logic [3:0] cnt;
    logic       fill;
    logic [7:0] data;
    logic [7:0] exp_res;
    int         exp_lat;
    int         exp_ld;
    int         exp_en;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] res, exp_r;
    int lat, nld, nen, cyc;
    logic busy_ok;

    vecs[0] = '{2'b00, 1'b0, 4'd2,  1'b1, 8'h0F, 8'h3F, 4,  1, 2};
    vecs[1] = '{2'b00, 1'b0, 4'd0,  1'b0, 8'h0F, 8'h0F, 2,  1, 0};
    vecs[2] = '{2'b01, 1'b1, 4'd3,  1'b0, 8'h00, 8'h01, 4,  0, 3};
`ifdef SHIFT8_SEQ_ROTATE_EN
    vecs[3] = '{2'b10, 1'b0, 4'd1,  1'b0, 8'h81, 8'h03, 3,  1, 1};
    vecs[8] = '{2'b10, 1'b1, 4'd3,  1'b1, 8'h96, 8'hD2, 5,  1, 3};
`else
    vecs[3] = '{2'b10, 1'b0, 4'd1,  1'b0, 8'h81, 8'h02, 3,  1, 1};
    vecs[8] = '{2'b10, 1'b1, 4'd3,  1'b1, 8'h96, 8'hF2, 5,  1, 3};
`endif
    vecs[4] = '{2'b00, 1'b1, 4'd12, 1'b0, 8'hFF, 8'h00, 10, 1, 8};
    vecs[5] = '{2'b11, 1'b0, 4'd5,  1'b1, 8'hA5, 8'h00, 2,  1, 0};
    vecs[6] = '{2'b01, 1'b0, 4'd0,  1'b1, 8'h00, 8'h00, 1,  0, 0};
    vecs[7] = '{2'b00, 1'b1, 4'd15, 1'b1, 8'h80, 8'hFF, 10, 1, 8};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {23'd0, sr_ld, sr_en, sr_dir, sr_sd, done, sr_d, result}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", cmd_ready, 1);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].op, vecs[i].dir, vecs[i].cnt, vecs[i].fill, vecs[i].data,
              res, lat, nld, nen, busy_ok);
      exp_r = model(vecs[i].op, vecs[i].dir, vecs[i].cnt, vecs[i].fill, vecs[i].data, ref_q);
      ref_q = exp_r;
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_model", i), res, exp_r);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_ld_cycles", i), nld, vecs[i].exp_ld);
      check($sformatf("vec%0d_en_cycles", i), nen, vecs[i].exp_en);
      check($sformatf("vec%0d_busy_ready", i), busy_ok, 1);
      check($sformatf("vec%0d_dir_held", i), sr_dir, vecs[i].dir);
    end

    // Result holds after the done pulse
    exp_r = ref_q;
    repeat (3) @(posedge clk);
    #1;
    check("result_held", result, exp_r);
    check("done_single_pulse", done, 0);

    // Back-to-back with cmd_valid held: B accepted on the edge closing A's done cycle
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dir = 1'b0; cmd_cnt = 4'd1;
    cmd_fill = 1'b0; cmd_data = 8'h01;
    @(posedge clk); #1;
    cmd_op = 2'b00; cmd_dir = 1'b1; cmd_cnt = 4'd1; cmd_fill = 1'b1; cmd_data = 8'h40;
    cyc = 0; busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (cmd_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_busy_ready", busy_ok, 1);
    check("b2b_a_latency", cyc, 3);
    check("b2b_a_result", result, 8'h02);
    check("b2b_ready_at_done", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_b_accepted", {cmd_ready, sr_ld, sr_d}, {1'b0, 1'b1, 8'h40});
    cyc = 0;
    while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("b2b_b_result", result, 8'hA0);
    ref_q = 8'hA0;

    // Reset during SHIFT: LOAD 0x00, shifting in ones to the left
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dir = 1'b0; cmd_cnt = 4'd8;
    cmd_fill = 1'b1; cmd_data = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_en", sr_en, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("reset_kills_en", {sr_en, done}, 2'b00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || !cmd_ready || sr_en) cyc++;
    end
    check("no_done_after_abort", cyc, 0);
    ref_q = 8'h07;
    run_cmd(2'b01, 1'b0, 4'd0, 1'b0, 8'h00, res, lat, nld, nen, busy_ok);
    check("abort_left_register", res, 8'h07);

    // Randomised commands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic dir, fill;
      logic [3:0] cnt;
      logic [7:0] data;
      op   = 2'($urandom_range(0, 3));
      dir  = 1'($urandom_range(0, 1));
      fill = 1'($urandom_range(0, 1));
      cnt  = 4'($urandom_range(0, 15));
      data = 8'($urandom_range(0, 255));
      run_cmd(op, dir, cnt, fill, data, res, lat, nld, nen, busy_ok);
      exp_r = model(op, dir, cnt, fill, data, ref_q);
      ref_q = exp_r;
      check($sformatf("rnd%0d_result", i), res, exp_r);
      check($sformatf("rnd%0d_latency", i), lat, model_lat(op, cnt));
      check($sformatf("rnd%0d_en_cycles", i), nen, (eff_op(op) == 3) ? 0 : sat(cnt));
    end

    check("ld_en_never_together", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
